// File: rtl/semafor_pkg.sv
// Shared encodings for the self-timed traffic-light controller: phase codes,
// FSM state encoding and the registered-lamp decode helpers.
package semafor_pkg;

   localparam logic [1:0] PH_RED = 2'b00;
   localparam logic [1:0] PH_YEL = 2'b01;
   localparam logic [1:0] PH_GRN = 2'b11;
   localparam logic [1:0] PH_GY  = 2'b10;

   typedef enum logic [2:0] {
      ST_RED   = 3'd0,
      ST_YEL   = 3'd1,
      ST_GRN   = 3'd2,
      ST_GY    = 3'd3,
      ST_NIGHT = 3'd4
   } state_e;

   // Returns {red, yellow, green}; in NIGHT only the yellow lamp follows blink.
   function automatic logic [2:0] lamp_decode(input state_e st, input logic blink);
      logic [2:0] l;
      case (st)
         ST_RED:   l = 3'b100;
         ST_YEL:   l = 3'b010;
         ST_GRN:   l = 3'b001;
         ST_GY:    l = 3'b011;
         ST_NIGHT: l = {1'b0, blink, 1'b0};
         default:  l = 3'b100;
      endcase
      return l;
   endfunction

   function automatic logic [1:0] phase_decode(input state_e st);
      logic [1:0] p;
      case (st)
         ST_YEL:  p = PH_YEL;
         ST_GRN:  p = PH_GRN;
         ST_GY:   p = PH_GY;
         default: p = PH_RED;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/semafor_timer_if.sv
// Control inputs and lamp/phase outputs of the traffic-light controller.
interface semafor_timer_if;
   logic       en;
   logic       night;
   logic       ped_req;
   logic [1:0] phase;
   logic       red;
   logic       yellow;
   logic       green;
   logic       phase_start;

   modport master (
      output en, night, ped_req,
      input  phase, red, yellow, green, phase_start
   );

   modport slave (
      input  en, night, ped_req,
      output phase, red, yellow, green, phase_start
   );
endinterface

// File: rtl/semafor_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles;
// the count freezes while en is low so resuming adds no extra ticks.
module semafor_prescaler #(
   parameter int CLK_DIV = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int         W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (tick)    cnt_d = '0;
      else if (en) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/semafor_timer.sv
// Self-timed traffic-light FSM with pedestrian green shortening, night
// flashing-yellow mode and run enable; all lamp/phase outputs are registered.
module semafor_timer
   import semafor_pkg::*;
#(
   parameter int CLK_DIV = 50000000,
   parameter int CNT_W   = 8,
   parameter int T_RED   = 10,
   parameter int T_YEL   = 2,
   parameter int T_GRN   = 10,
   parameter int T_GMIN  = 3,
   parameter int T_GY    = 2,
   parameter int T_BLINK = 1
) (
   input  logic            clk,
   input  logic            reset,
   semafor_timer_if.slave  bus
);

   localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(T_RED - 1);
   localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YEL - 1);
   localparam logic [CNT_W-1:0] GRN_LAST   = CNT_W'(T_GRN - 1);
   localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(T_GMIN - 1);
   localparam logic [CNT_W-1:0] GY_LAST    = CNT_W'(T_GY - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(T_BLINK - 1);

   logic             tick;
   logic             changed;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             ped_pend_q, ped_pend_d;
   logic             blink_q, blink_d;
   logic [2:0]       lamps_q, lamps_d;
   logic [1:0]       phase_q, phase_d;
   logic             phase_start_q, phase_start_d;

   semafor_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (bus.en),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      blink_d    = blink_q;
      ped_pend_d = ped_pend_q;
      if (bus.ped_req && (state_q == ST_YEL || state_q == ST_GRN || state_q == ST_GY))
         ped_pend_d = 1'b1;

      if (tick) begin
         timer_d = timer_q + CNT_W'(1);
         if (state_q == ST_NIGHT) begin
            if (!bus.night) begin
               state_d = ST_RED;
            end else if (timer_q == BLINK_LAST) begin
               blink_d = ~blink_q;
               timer_d = '0;
            end
         end else if (bus.night) begin
            // Night wins over any day transition due on the same tick.
            state_d = ST_NIGHT;
            blink_d = 1'b0;
         end else begin
            case (state_q)
               ST_RED: if (timer_q == RED_LAST) state_d = ST_YEL;
               ST_YEL: if (timer_q == YEL_LAST) state_d = ST_GRN;
               ST_GRN: if ((timer_q == GRN_LAST) || (ped_pend_q && timer_q >= GMIN_LAST))
                          state_d = ST_GY;
               ST_GY:  if (timer_q == GY_LAST)  state_d = ST_RED;
               default: state_d = ST_RED;
            endcase
         end
      end

      changed = (state_d != state_q);
      if (changed) timer_d = '0;
      // Clearing on entry to RED beats a same-cycle request.
      if (changed && state_d == ST_RED) ped_pend_d = 1'b0;

      lamps_d       = lamp_decode(state_d, blink_d);
      phase_d       = phase_decode(state_d);
      phase_start_d = changed;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RED;
         timer_q       <= '0;
         ped_pend_q    <= 1'b0;
         blink_q       <= 1'b0;
         lamps_q       <= 3'b100;
         phase_q       <= PH_RED;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         ped_pend_q    <= ped_pend_d;
         blink_q       <= blink_d;
         lamps_q       <= lamps_d;
         phase_q       <= phase_d;
         phase_start_q <= phase_start_d;
      end
   end

   assign bus.red         = lamps_q[2];
   assign bus.yellow      = lamps_q[1];
   assign bus.green       = lamps_q[0];
   assign bus.phase       = phase_q;
   assign bus.phase_start = phase_start_q;

endmodule

// File: doc/semafor_timer.md
Name: semafor_timer

Overview:
Self-timed traffic-light controller. Generates the 2-bit phase code {contr1,contr0} and the red/yellow/green lamp drives internally instead of taking them as inputs.
- Phase durations, clock prescale and night-blink rate are parameters.
- Adds pedestrian-request green shortening, night (flashing yellow) mode and a run enable.
- Sits between the board clock and the lamp drivers; the phase output can also feed the existing phase-to-lamp decoder.

Parameters:
CLK_DIV, 50000000, clk cycles per time tick (>=1)
CNT_W, 8, width of phase timer; every duration below must be < 2**CNT_W
T_RED, 10, ticks in RED (>=1)
T_YEL, 2, ticks in YELLOW (red→green transition) (>=1)
T_GRN, 10, ticks in GREEN (>=1)
T_GMIN, 3, minimum GREEN ticks when pedestrian request pending (1..T_GRN)
T_GY, 2, ticks in GREEN_YELLOW (>=1)
T_BLINK, 1, ticks per yellow half-period in night mode (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  run enable; 0 freezes all counters and state
night  in  1  level; 1 requests night mode
ped_req  in  1  pedestrian button, any pulse width ≥1 cycle
phase  out  2  phase code: 00 RED, 01 YELLOW, 11 GREEN, 10 GREEN_YELLOW (00 in night mode)
red  out  1  red lamp
yellow  out  1  yellow lamp
green  out  1  green lamp
phase_start  out  1  one-cycle pulse in the first cycle of every new state

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset values: state RED, prescaler=0, timer=0, ped_pend=0, blink=0. Outputs: red=1, yellow=0, green=0, phase=00, phase_start=0.
- Reset asserted mid-operation overrides everything on the next edge, including night mode and en=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en=1 and wraps.
  - tick=1 for one cycle when count==CLK_DIV-1 and en=1.
  - CLK_DIV=1 gives tick every enabled cycle.
- Timer:
  - Increments on tick.
  - Cleared to 0 on every state change.
  - Never wraps, because transitions occur before overflow.
- States: RED, YEL, GRN, GY, NIGHT. Day sequence is RED→YEL→GRN→GY→RED.
- Day transitions, evaluated only on tick, state changes at that edge:
  - RED: timer==T_RED-1 → YEL.
  - YEL: timer==T_YEL-1 → GRN.
  - GRN: (timer==T_GRN-1) or (ped_pend and timer>=T_GMIN-1) → GY.
  - GY: timer==T_GY-1 → RED.
  - A state therefore lasts exactly T_x*CLK_DIV enabled cycles.
- Pedestrian request:
  - ped_pend set on any cycle with ped_req=1 while state ∈ {YEL, GRN, GY}.
  - Ignored in RED and NIGHT.
  - Cleared on the edge entering RED.
  - Set and clear on the same edge: clear wins.
  - A request arriving in GRN after timer>=T_GMIN-1 ends green at the next tick.
- Night mode:
  - night=1 sampled on tick, from any day state → NIGHT at that edge.
  - blink is cleared on entry, then toggles when timer==T_BLINK-1, with timer cleared on toggle.
  - Outputs in NIGHT: yellow=blink, red=0, green=0, phase=00.
  - night=0 sampled on tick while in NIGHT → RED with timer=0, giving a full T_RED.
  - night takes priority over a same-tick day transition.
- en=0:
  - Prescaler, timer, blink and state hold; outputs hold.
  - ped_req is still latched.
  - Resuming continues exactly where it stopped; no extra ticks.
- Lamp decode of the registered state, with no glitches:
  - RED: 1/0/0.
  - YEL: 0/1/0.
  - GRN: 0/0/1.
  - GY: 0/1/1.
- phase_start=1 in the cycle after a state-changing edge, i.e. the first cycle the new state is visible. It is 0 after reset.
- Blink toggles are not state changes and do not pulse phase_start.

Decomposition:
- Shared package semafor_pkg holds:
  - phase codes PH_RED=2'b00, PH_YEL=2'b01, PH_GRN=2'b11, PH_GY=2'b10;
  - 3-bit state encoding ST_RED, ST_YEL, ST_GRN, ST_GY, ST_NIGHT;
  - lamp-decode function state→{red,yellow,green}.
- One sub-module, semafor_prescaler (CLK_DIV; clk, reset, en → tick), for reuse by other timed blocks.

Test Plan:
Common parameters for all scenarios: CLK_DIV=4, T_RED=5, T_YEL=2, T_GRN=6, T_GMIN=2, T_GY=2, T_BLINK=1.
- Reset, en=1, night=0 → red=1 for cycles 0-19, then YEL for 8, GRN for 24, GY for 8, RED at cycle 60; phase 00→01→11→10→00; phase_start pulses at cycles 20, 28, 52, 60.
- Single-cycle ped_req at cycle 21 (YEL) → GRN lasts 8 cycles (28-35), GY at cycle 36, ped_pend cleared at RED; ped_req at cycle 5 (RED) → no effect, full 24-cycle green.
- night=1 at cycle 10 → NIGHT from cycle 12, yellow toggles every 4 cycles, red=green=0, phase=00; night=0 → RED at next tick, red held 20 cycles.
- en=0 for cycles 8-17 → first YEL at cycle 30 instead of 20; outputs constant during the freeze.
- reset=1 for one cycle while in GRN → next cycle red=1, yellow=0, green=0, phase=00; YEL exactly 20 cycles after reset release.
- T_GMIN=T_GRN=6 with ped_req held high throughout → green still 24 cycles; simultaneous tick with night=1 at GY end → NIGHT, not RED.
